// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// master drives requests (fetcher + mem_ctrl model); slave is the cache itself.
interface inst_cache_if;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_flag;
  logic [31:0] IF_inst;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_flag;
  logic [31:0] MC_inst;

  modport master (
    output IF_req, IF_addr, MC_flag, MC_inst,
    input  IF_flag, IF_inst, MC_req, MC_addr
  );

  modport slave (
    input  IF_req, IF_addr, MC_flag, MC_inst,
    output IF_flag, IF_inst, MC_req, MC_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with blocking miss fill
// and misprediction flush that drains an in-flight fill it cannot abort.
module inst_cache #(
  parameter int ICACHE_IDX_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            jump_wrong,
  inst_cache_if.slave     bus
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, RESP, DRAIN} state_e;

  state_e                  state_q;
  logic                    if_flag_q;
  logic [31:0]             if_inst_q;
  logic                    mc_req_q;
  logic [31:0]             mc_addr_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [ICACHE_IDX_W-1:0] req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    fill_en;
  logic                    unused_addr_bits;

  assign req_idx  = bus.IF_addr[ICACHE_IDX_W+1:2];
  assign req_tag  = bus.IF_addr[31:ICACHE_IDX_W+2];
  // The fill target comes from the held MC_addr, so it stays correct even
  // after a flush lets IF_addr wander off.
  assign fill_idx = mc_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag = mc_addr_q[31:ICACHE_IDX_W+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_en  = rdy && bus.MC_flag && ((state_q == MISS) || (state_q == DRAIN));
  assign unused_addr_bits = ^bus.IF_addr[1:0];

  assign bus.IF_flag = if_flag_q;
  assign bus.IF_inst = if_inst_q;
  assign bus.MC_req  = mc_req_q;
  assign bus.MC_addr = mc_addr_q;

  // NOTE: tag/data storage has no reset; only the valid bits must be cleared,
  // and leaving the arrays reset-free lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.MC_inst;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      if_flag_q <= 1'b0;
      if_inst_q <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      valid_q   <= '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if_flag_q <= 1'b0;
          if (!jump_wrong && bus.IF_req) begin
            if (hit) begin
              if_flag_q <= 1'b1;
              if_inst_q <= data_mem[req_idx];
              state_q   <= RESP;
            end else begin
              mc_req_q  <= 1'b1;
              mc_addr_q <= {bus.IF_addr[31:2], 2'b00};
              state_q   <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.MC_flag) begin
            valid_q[fill_idx] <= 1'b1;
            mc_req_q          <= 1'b0;
            if (jump_wrong) begin
              state_q <= IDLE;
            end else begin
              if_flag_q <= 1'b1;
              if_inst_q <= bus.MC_inst;
              state_q   <= RESP;
            end
          end else if (jump_wrong) begin
            state_q <= DRAIN;
          end
        end
        RESP: begin
          // One guaranteed bubble: the request is not looked at here.
          if_flag_q <= 1'b0;
          state_q   <= IDLE;
        end
        DRAIN: begin
          if (bus.MC_flag) begin
            valid_q[fill_idx] <= 1'b1;
            mc_req_q          <= 1'b0;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit, conflict, flush drain,
// rdy stalls and asynchronous reset, with hand-computed expectations.
module tb_inst_cache;

  logic clk;
  logic rst;
  logic rdy;
  logic jump_wrong;
  int   tests;
  int   fails;

  inst_cache_if bus ();

  inst_cache #(.ICACHE_IDX_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jump_wrong (jump_wrong),
    .bus        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    rdy = 1'b1;
    jump_wrong = 1'b0;
    bus.IF_req  = 1'b0;
    bus.IF_addr = '0;
    bus.MC_flag = 1'b0;
    bus.MC_inst = '0;
    #12;
    check("rst_if_flag", {31'b0, bus.IF_flag}, 32'd0);
    check("rst_if_inst", bus.IF_inst, 32'h0);
    check("rst_mc_req",  {31'b0, bus.MC_req}, 32'd0);
    check("rst_mc_addr", bus.MC_addr, 32'h0);
    rst = 1'b0;
    tick();

    // Cold miss on 0x0
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0000;
    tick();
    check("cold_mc_req",  {31'b0, bus.MC_req}, 32'd1);
    check("cold_mc_addr", bus.MC_addr, 32'h0);
    check("cold_no_flag", {31'b0, bus.IF_flag}, 32'd0);
    tick();
    check("cold_hold_req", {31'b0, bus.MC_req}, 32'd1);
    bus.MC_flag = 1'b1; bus.MC_inst = 32'h0000_0013;
    tick();
    bus.MC_flag = 1'b0;
    check("cold_if_flag", {31'b0, bus.IF_flag}, 32'd1);
    check("cold_if_inst", bus.IF_inst, 32'h0000_0013);
    check("cold_req_drop", {31'b0, bus.MC_req}, 32'd0);
    tick();
    check("cold_bubble", {31'b0, bus.IF_flag}, 32'd0);

    // Hit on 0x0 (IF_req still high from above)
    tick();
    check("hit_if_flag", {31'b0, bus.IF_flag}, 32'd1);
    check("hit_if_inst", bus.IF_inst, 32'h0000_0013);
    check("hit_no_mc",   {31'b0, bus.MC_req}, 32'd0);
    bus.IF_req = 1'b0;
    tick();
    check("hit_bubble", {31'b0, bus.IF_flag}, 32'd0);

    // Conflict: 0x80 shares index 0 with 0x0
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0080;
    tick();
    check("conf_mc_req",  {31'b0, bus.MC_req}, 32'd1);
    check("conf_mc_addr", bus.MC_addr, 32'h0000_0080);
    bus.MC_flag = 1'b1; bus.MC_inst = 32'hAAAA_0001;
    tick();
    bus.MC_flag = 1'b0; bus.IF_req = 1'b0;
    check("conf_if_inst", bus.IF_inst, 32'hAAAA_0001);
    tick();
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0000;
    tick();
    check("conf_remiss_req",  {31'b0, bus.MC_req}, 32'd1);
    check("conf_remiss_addr", bus.MC_addr, 32'h0);
    check("conf_remiss_flag", {31'b0, bus.IF_flag}, 32'd0);
    bus.MC_flag = 1'b1; bus.MC_inst = 32'h0000_0013;
    tick();
    bus.MC_flag = 1'b0; bus.IF_req = 1'b0;
    check("conf_refill_inst", bus.IF_inst, 32'h0000_0013);
    tick();

    // Flush two cycles into a miss on 0x100
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0100;
    tick();
    check("fl_mc_addr", bus.MC_addr, 32'h0000_0100);
    tick();
    jump_wrong = 1'b1; bus.IF_req = 1'b0;
    tick();
    jump_wrong = 1'b0;
    check("fl_drain_req",  {31'b0, bus.MC_req}, 32'd1);
    check("fl_drain_flag", {31'b0, bus.IF_flag}, 32'd0);
    tick();
    check("fl_drain_hold", {31'b0, bus.MC_req}, 32'd1);
    bus.MC_flag = 1'b1; bus.MC_inst = 32'h0050_0093;
    tick();
    bus.MC_flag = 1'b0;
    check("fl_fill_req",  {31'b0, bus.MC_req}, 32'd0);
    check("fl_fill_flag", {31'b0, bus.IF_flag}, 32'd0);
    tick();
    check("fl_idle_flag", {31'b0, bus.IF_flag}, 32'd0);
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0100;
    tick();
    check("fl_hit_flag", {31'b0, bus.IF_flag}, 32'd1);
    check("fl_hit_inst", bus.IF_inst, 32'h0050_0093);
    check("fl_hit_no_mc", {31'b0, bus.MC_req}, 32'd0);
    bus.IF_req = 1'b0;
    tick();

    // rdy stall in MISS (with a lost MC_flag) and in RESP
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0204;
    tick();
    check("rdy_mc_addr", bus.MC_addr, 32'h0000_0204);
    rdy = 1'b0;
    bus.MC_flag = 1'b1; bus.MC_inst = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.MC_flag = 1'b0;
      check("rdy_miss_req",  {31'b0, bus.MC_req}, 32'd1);
      check("rdy_miss_addr", bus.MC_addr, 32'h0000_0204);
      check("rdy_miss_flag", {31'b0, bus.IF_flag}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("rdy_lost_flag_req", {31'b0, bus.MC_req}, 32'd1);
    bus.MC_flag = 1'b1; bus.MC_inst = 32'h1111_1111;
    tick();
    bus.MC_flag = 1'b0;
    check("rdy_fill_flag", {31'b0, bus.IF_flag}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_resp_flag", {31'b0, bus.IF_flag}, 32'd1);
      check("rdy_resp_inst", bus.IF_inst, 32'h1111_1111);
    end
    rdy = 1'b1;
    tick();
    check("rdy_resume_bubble", {31'b0, bus.IF_flag}, 32'd0);
    tick();
    check("rdy_resume_hit", {31'b0, bus.IF_flag}, 32'd1);
    check("rdy_resume_inst", bus.IF_inst, 32'h1111_1111);
    bus.IF_req = 1'b0;
    tick();

    // jump_wrong in IDLE suppresses the lookup
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0300; jump_wrong = 1'b1;
    tick();
    check("jw_idle_no_req",  {31'b0, bus.MC_req}, 32'd0);
    check("jw_idle_no_flag", {31'b0, bus.IF_flag}, 32'd0);
    jump_wrong = 1'b0;
    tick();
    check("ar_mc_req", {31'b0, bus.MC_req}, 32'd1);
    check("ar_mc_addr", bus.MC_addr, 32'h0000_0300);

    // Async reset between edges mid-MISS
    bus.IF_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_req_now",  {31'b0, bus.MC_req}, 32'd0);
    check("ar_addr_now", bus.MC_addr, 32'h0);
    #2 rst = 1'b0;
    bus.MC_flag = 1'b1; bus.MC_inst = 32'h2222_2222;
    tick();
    bus.MC_flag = 1'b0;
    check("ar_stale_flag", {31'b0, bus.IF_flag}, 32'd0);
    check("ar_stale_req",  {31'b0, bus.MC_req}, 32'd0);
    bus.IF_req = 1'b1; bus.IF_addr = 32'h0000_0300;
    tick();
    check("ar_remiss_req",  {31'b0, bus.MC_req}, 32'd1);
    check("ar_remiss_flag", {31'b0, bus.IF_flag}, 32'd0);
    bus.IF_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 The block SHALL have one clock and reset; reset is asynchronous and active-high, with ports named clk and rst.
REQ-002 Parameter: ICACHE_IDX_W, default 5, index width in bits (lines = 2^ICACHE_IDX_W, one 32-bit word per line).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rdy  input  1  low = freeze all state and hold all outputs.
REQ-006 jump_wrong  input  1  ROB misprediction flush.
REQ-007 IF_req  input  1  instruction fetch request from inst_fetcher, held high until IF_flag.
REQ-008 IF_addr  input  32  fetch address; bits [1:0] are ignored.
REQ-009 IF_flag  output  1  one-cycle pulse: IF_inst is valid.
REQ-010 IF_inst  output  32  fetched instruction.
REQ-011 MC_req  output  1  miss fill request to mem_ctrl, held high until MC_flag.
REQ-012 MC_addr  output  32  fill address, word-aligned ({tag, index, 2'b00}).
REQ-013 MC_flag  input  1  one-cycle pulse: MC_inst is valid.
REQ-014 MC_inst  input  32  fill data from mem_ctrl.

Function
REQ-015 Organisation SHALL be direct-mapped: index = IF_addr[ICACHE_IDX_W+1:2]; tag = IF_addr[31:ICACHE_IDX_W+2]; storage = valid bit, tag and data per line.
REQ-016 Hit SHALL mean valid[index] && tag[index] == tag(IF_addr), evaluated combinationally in IDLE.
REQ-017 The FSM SHALL have states IDLE, MISS, RESP and DRAIN.
REQ-018 IDLE, IF_req && hit: at the edge, IF_flag<=1, IF_inst<=data[index], go to RESP; latency is request edge + 1 cycle.
REQ-019 IDLE, IF_req && miss: at the edge, MC_req<=1, MC_addr<={IF_addr[31:2],2'b00}, go to MISS.
REQ-020 MISS: MC_req and MC_addr SHALL be held stable; on MC_flag, write data/tag, set valid, IF_flag<=1, IF_inst<=MC_inst, MC_req<=0, go to RESP.
REQ-021 RESP: IF_flag<=0, go to IDLE; IF_req SHALL be ignored in RESP, which guarantees one bubble so IF can drop or change its request.
REQ-022 IF_flag SHALL never be high for two consecutive cycles.
REQ-023 jump_wrong in IDLE or RESP: IF_flag<=0, go to IDLE; no lookup is performed that cycle.
REQ-024 jump_wrong in MISS without MC_flag: go to DRAIN with MC_req kept high, because mem_ctrl cannot abort a fetch.
REQ-025 DRAIN: on MC_flag, fill the line, MC_req<=0, go to IDLE; IF_flag SHALL stay 0. jump_wrong in DRAIN has no further effect.
REQ-026 jump_wrong and MC_flag together in MISS: fill the line, IF_flag stays 0, MC_req<=0, go to IDLE.
REQ-027 rdy low: no state, array or output change; an MC_flag pulse arriving while rdy is low is lost (mem_ctrl is frozen by the same rdy).
REQ-028 jump_wrong SHALL NOT invalidate any line; lines are invalidated only by reset.
REQ-029 Only MC fills write the array; there is no write or store path (self-modifying code is unsupported).

Reset
REQ-030 On rst: state=IDLE, IF_flag=0, IF_inst=0, MC_req=0, MC_addr=0, all valid bits=0. Tag and data contents are don't-care.
REQ-031 Reset asserted mid-MISS or mid-DRAIN SHALL abandon the fill; a later MC_flag in IDLE SHALL be ignored.

Verification
REQ-032 Cold miss: IF_req, IF_addr=0x0 after reset -> MC_req=1, MC_addr=0x0 next cycle; MC_flag with MC_inst=0x00000013 -> IF_flag=1, IF_inst=0x00000013 one cycle later, then RESP bubble.
REQ-033 Hit: repeat IF_addr=0x0 -> IF_flag=1 with 0x00000013 exactly one cycle after the sampling edge; MC_req stays 0.
REQ-034 Conflict: fill 0x0, then request 0x80 (same index, ICACHE_IDX_W=5) -> miss, MC_addr=0x80; a following request to 0x0 -> miss again.
REQ-035 Flush mid-miss: jump_wrong 2 cycles into MISS for 0x100 -> MC_req held until MC_flag, IF_flag never pulses; a later request to 0x100 hits.
REQ-036 rdy: drop rdy for 3 cycles during MISS and during RESP -> MC_req, MC_addr, IF_flag and state are unchanged across the stall, and the sequence then resumes normally.
REQ-037 Async reset: assert rst between clock edges in MISS -> MC_req=0 immediately, without waiting for an edge; a request to the same address afterwards misses.
